exc_ctrl: RTL
=============

# exc_ctrl

Exception/interrupt sequencing controller for the 5-stage MIPS core. It sits at the MEM/commit boundary, between the pipeline and the CP0 register file. It collects per-instruction exception flags, synchronises hardware interrupts, picks the single highest-priority event, and drives the CP0 update strobes. It also owns the pipeline flush and the fetch-redirect handshake toward the exception vector or the ERET target.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect target for every exception and interrupt
- SYNC_STAGES, 2, flop depth of the hardware-interrupt synchroniser (≥2)

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- int_i  in  6  raw hardware interrupt lines, asynchronous
- hw_ip_o  out  6  synchronised interrupt lines, to CP0 Cause.IP[7:2]
- cm_valid  in  1  an instruction is at the commit point this cycle
- cm_pc  in  32  PC of the committing instruction
- cm_bd  in  1  committing instruction is in a branch delay slot
- cm_adel_if, cm_ri, cm_ov, cm_sys, cm_bp, cm_adel_d, cm_ades  in  1 each  exception flags
- cm_eret  in  1  committing instruction is ERET
- cm_daddr  in  32  data address for cm_adel_d / cm_ades
- st_ie, st_exl  in  1 each  CP0 Status.IE and Status.EXL
- st_im  in  8  CP0 Status.IM
- ca_ip  in  8  CP0 Cause.IP, current value
- epc_i  in  32  CP0 EPC, current value
- exc_valid  out  1  one-cycle strobe that updates CP0 (EPC, Cause.BD, Cause.ExcCode, Status.EXL←1)
- exc_code  out  5  ExcCode
- exc_epc  out  32  value to write into EPC
- exc_bd  out  1  value to write into Cause.BD
- bva_we  out  1  write strobe for BadVAddr
- bva_o  out  32  value to write into BadVAddr
- eret_valid  out  1  one-cycle strobe that clears Status.EXL
- flush  out  1  kill all instructions younger than and including the commit slot
- redir_valid / redir_ready  out / in  1  redirect handshake with fetch
- redir_pc  out  32  fetch target

## Operation
- **Interrupt pending:** int_pend = st_ie & ~st_exl & |(ca_ip & st_im).
- **Priority:** INT(0x00) > AdEL-fetch(0x04) > RI(0x0A) > Ov(0x0C) > Sys(0x08) > Bp(0x09) > AdEL-data(0x04) > AdES(0x05) > ERET.
- **EPC value:** exc_epc = cm_bd ? cm_pc − 32'd4 : cm_pc. The subtraction is mod 2^32 and wraps silently. exc_bd = cm_bd.
- **BadVAddr source:** bva_we fires only for AdEL/AdES. AdEL-fetch uses cm_pc; AdEL-data and AdES use cm_daddr.
- **FSM states:** IDLE, REDIR.
- **In IDLE:**
  - The commit is sampled only when cm_valid=1.
  - If the commit carries an event, register the outputs and go to REDIR.
  - Exception or interrupt: redir_pc=EXC_VECTOR.
  - ERET alone: redir_pc=epc_i and eret_valid pulses; exc_valid stays low.
- **In REDIR:**
  - flush=1 and redir_valid=1; all commit inputs are ignored.
  - On redir_valid & redir_ready, return to IDLE.
- **Interrupt arrives with no valid commit:** no action. The interrupt is taken on the next cm_valid, against that instruction.
- **Simultaneous events:**
  - An exception on an ERET instruction beats the ERET: no eret_valid.
  - An interrupt beats any flag on the same instruction.

## Timing
- Reset value of every output is 0. The FSM resets to IDLE and the synchroniser flops clear.
- Interrupt latency: int_i to hw_ip_o takes SYNC_STAGES cycles.
- Event sampled at edge N (IDLE, cm_valid=1). From edge N+1:
  - exc_valid / eret_valid / bva_we are high for exactly one cycle.
  - flush and redir_valid rise in the same cycle.
- redir_valid, redir_pc and flush stay stable until the handshake cycle. All three drop the cycle after redir_ready is seen.
- Back-to-back events: the earliest next sample is the edge after the handshake completes.
- resetn asserted mid-REDIR: the redirect is abandoned immediately and asynchronously, and no strobe is replayed.

## Structure
- **Package exc_pkg:** ExcCode localparams (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV), the FSM state enum, and the EXC_VECTOR default.
- **Sub-module int_sync:** SYNC_STAGES-deep, 6-bit synchroniser with async active-low clear.
- The priority encoder lives in exc_ctrl.

## Test plan
- **Overflow in delay slot:** cm_ov=1, cm_bd=1, cm_pc=0xBFC0_1004 → exc_valid one cycle, exc_code=0x0C, exc_epc=0xBFC0_1000, exc_bd=1, redir_pc=0xBFC0_0380, bva_we=0.
- **Store address error:** cm_ades=1, cm_daddr=0x8000_0003 → exc_code=0x05, bva_we=1, bva_o=0x8000_0003. Hold redir_ready=0 for 3 cycles → flush/redir_valid held 3 cycles, deasserting the cycle after ready.
- **ERET:** cm_eret=1, epc_i=0xBFC0_2000 → eret_valid pulse, exc_valid=0, redir_pc=0xBFC0_2000. ERET+cm_ri → code 0x0A, no eret_valid.
- **Interrupt:** int_i[0] rises with st_ie=1, st_exl=0, st_im=0x04, ca_ip follows hw_ip_o → hw_ip_o[0] after 2 cycles. The next cm_valid with cm_sys=1 → code 0x00. With st_exl=1 → code 0x08.
- **Fetch-address priority:** cm_adel_if and cm_adel_d both set, cm_pc=0x0000_0002 → bva_o=0x0000_0002, code 0x04.
- **Reset mid-redirect:** resetn low during REDIR → all outputs 0 immediately. After release, FSM is IDLE and accepts a new commit.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared constants and types for the exception/interrupt sequencing controller.
package exc_pkg;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  typedef enum logic {S_IDLE, S_REDIR} exc_state_e;
endpackage

// File: rtl/int_sync.sv
// Multi-flop synchroniser for the raw hardware interrupt lines.
module int_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int W           = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [SYNC_STAGES-1:0][W-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
  end

  assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/exc_ctrl.sv
// Commit-point exception/interrupt sequencer: picks the winning event, strobes
// CP0 updates and holds the flush/redirect handshake toward fetch.
module exc_ctrl import exc_pkg::*; #(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  int_i,
  output logic [5:0]  hw_ip_o,
  input  logic        cm_valid,
  input  logic [31:0] cm_pc,
  input  logic        cm_bd,
  input  logic        cm_adel_if,
  input  logic        cm_ri,
  input  logic        cm_ov,
  input  logic        cm_sys,
  input  logic        cm_bp,
  input  logic        cm_adel_d,
  input  logic        cm_ades,
  input  logic        cm_eret,
  input  logic [31:0] cm_daddr,
  input  logic        st_ie,
  input  logic        st_exl,
  input  logic [7:0]  st_im,
  input  logic [7:0]  ca_ip,
  input  logic [31:0] epc_i,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic        bva_we,
  output logic [31:0] bva_o,
  output logic        eret_valid,
  output logic        flush,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc
);
  exc_state_e  state_q, state_d;
  logic        int_pend, is_exc, bva_hit, bva_from_pc, capture;
  logic [4:0]  code;
  logic [31:0] redir_pc_q;

  int_sync #(.SYNC_STAGES(SYNC_STAGES), .W(6)) u_sync (
    .clk(clk), .resetn(resetn), .d(int_i), .q(hw_ip_o)
  );

  assign int_pend = st_ie & ~st_exl & |(ca_ip & st_im);

  // Fixed-priority encoder; an interrupt wins over every flag on the same slot.
  always_comb begin
    is_exc      = 1'b1;
    code        = EXC_INT;
    bva_hit     = 1'b0;
    bva_from_pc = 1'b0;
    if (int_pend)        code = EXC_INT;
    else if (cm_adel_if) begin code = EXC_ADEL; bva_hit = 1'b1; bva_from_pc = 1'b1; end
    else if (cm_ri)      code = EXC_RI;
    else if (cm_ov)      code = EXC_OV;
    else if (cm_sys)     code = EXC_SYS;
    else if (cm_bp)      code = EXC_BP;
    else if (cm_adel_d)  begin code = EXC_ADEL; bva_hit = 1'b1; end
    else if (cm_ades)    begin code = EXC_ADES; bva_hit = 1'b1; end
    else                 is_exc = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: if (cm_valid && (is_exc || cm_eret)) begin
        capture = 1'b1;
        state_d = S_REDIR;
      end
      S_REDIR: if (redir_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      exc_valid  <= 1'b0;
      eret_valid <= 1'b0;
      bva_we     <= 1'b0;
      exc_code   <= '0;
      exc_epc    <= '0;
      exc_bd     <= 1'b0;
      bva_o      <= '0;
      redir_pc_q <= '0;
    end else begin
      exc_valid  <= 1'b0;
      eret_valid <= 1'b0;
      bva_we     <= 1'b0;
      if (capture) begin
        exc_valid  <= is_exc;
        eret_valid <= ~is_exc;
        bva_we     <= bva_hit;
        exc_code   <= code;
        exc_epc    <= cm_bd ? cm_pc - 32'd4 : cm_pc;
        exc_bd     <= cm_bd;
        if (bva_hit) bva_o <= bva_from_pc ? cm_pc : cm_daddr;
        redir_pc_q <= is_exc ? EXC_VECTOR : epc_i;
      end
    end
  end

  // Redirect outputs derive from the state flop so an async reset drops them at once.
  assign flush       = (state_q == S_REDIR);
  assign redir_valid = (state_q == S_REDIR);
  assign redir_pc    = (state_q == S_REDIR) ? redir_pc_q : '0;
endmodule
